// File: rtl/vpu_ctrl.sv
// vpu_ctrl: tile sequencer for the VPU lanes. It latches the per-tile mode and row
// count, counts valid results on each lane, owns the per-lane bias registers, and
// flags protocol errors in a sticky err bit.
// Optional build macro VPU_CTRL_PERF_EN adds the 32-bit perf_cycles busy-cycle counter.
module vpu_ctrl #(
    parameter int unsigned VPU_WIDTH     = 4,
    parameter int unsigned DATA_WIDTH_IN = 32,
    parameter int unsigned ROW_W         = 16,
    localparam int unsigned LANE_W       = (VPU_WIDTH > 1) ? $clog2(VPU_WIDTH) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cfg_start,
    input  logic                            cfg_abort,
    input  logic [2:0]                      cfg_mode,
    input  logic [ROW_W-1:0]                cfg_rows,
    input  logic                            bias_wr_en,
    input  logic [LANE_W-1:0]               bias_wr_lane,
    input  logic signed [DATA_WIDTH_IN-1:0] bias_wr_data,
    input  logic                            sys_valid_in [VPU_WIDTH],
    output logic [2:0]                      vpu_mode,
    output logic signed [DATA_WIDTH_IN-1:0] vpu_bias_data_out [VPU_WIDTH],
    output logic                            busy,
    output logic                            done,
`ifdef VPU_CTRL_PERF_EN
    output logic [31:0]                     perf_cycles,
`endif
    output logic                            err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [ROW_W-1:0] rows_q;
    logic [ROW_W-1:0] cnt_q [VPU_WIDTH];
    logic [ROW_W-1:0] cnt_d [VPU_WIDTH];

    logic start_acc_c;
    logic all_reach_c;
    logic excess_c;
    logic idle_valid_c;
    logic bias_oob_c;
    logic bias_wr_ok_c;
    logic err_set_c;

    // A start is honoured only in IDLE; abort in IDLE is ignored so start wins.
    assign start_acc_c  = (state_q == S_IDLE) && cfg_start;
    assign bias_oob_c   = 32'(bias_wr_lane) >= VPU_WIDTH;
    assign bias_wr_ok_c = bias_wr_en && (state_q == S_IDLE) && !bias_oob_c;

    // Per-lane counter update plus the completion and lane-error summaries.
    always_comb begin
        all_reach_c  = 1'b1;
        excess_c     = 1'b0;
        idle_valid_c = 1'b0;
        for (int i = 0; i < VPU_WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (start_acc_c) begin
                cnt_d[i] = '0;
            end else if ((state_q == S_RUN) && sys_valid_in[i] && (cnt_q[i] < rows_q)) begin
                cnt_d[i] = cnt_q[i] + ROW_W'(1);
            end
            // Uses the updated count so final valids arriving together still finish RUN.
            if (cnt_d[i] != rows_q) begin
                all_reach_c = 1'b0;
            end
            if (((state_q == S_RUN) || (state_q == S_DRAIN)) && sys_valid_in[i]
                && (cnt_q[i] >= rows_q)) begin
                excess_c = 1'b1;
            end
            if ((state_q == S_IDLE) && sys_valid_in[i]) begin
                idle_valid_c = 1'b1;
            end
        end
    end

    // Every protocol violation that sets the sticky error flag.
    assign err_set_c = (cfg_start && (state_q != S_IDLE))
                     || excess_c
                     || idle_valid_c
                     || (bias_wr_en && ((state_q != S_IDLE) || bias_oob_c));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a zero-row tile jumps straight to DONE; abort only in RUN/DRAIN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    state_d = (cfg_rows == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (cfg_abort) begin
                    state_d = S_IDLE;
                end else if (all_reach_c) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = cfg_abort ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Lane result counters.
    always_ff @(posedge clk) begin
        for (int i = 0; i < VPU_WIDTH; i++) begin
            if (rst) begin
                cnt_q[i] <= '0;
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Tile configuration and registered status outputs, aligned with the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            vpu_mode <= 3'b000;
            rows_q   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (start_acc_c) begin
                vpu_mode <= cfg_mode;
                rows_q   <= cfg_rows;
            end
            busy <= (state_d == S_RUN) || (state_d == S_DRAIN);
            done <= (state_d == S_DONE);
            if (err_set_c) begin
                err <= 1'b1;
            end
        end
    end

    // Bias registers drive the VPU directly; writes land only while idle.
    always_ff @(posedge clk) begin
        for (int i = 0; i < VPU_WIDTH; i++) begin
            if (rst) begin
                vpu_bias_data_out[i] <= '0;
            end else if (bias_wr_ok_c && (bias_wr_lane == LANE_W'(i))) begin
                vpu_bias_data_out[i] <= bias_wr_data;
            end
        end
    end

`ifdef VPU_CTRL_PERF_EN
    // Saturating count of busy cycles for the current tile; held after completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles <= '0;
        end else if (start_acc_c) begin
            perf_cycles <= '0;
        end else if (((state_q == S_RUN) || (state_q == S_DRAIN)) && (perf_cycles != '1)) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vpu_ctrl.sv
// tb_vpu_ctrl: directed vector table plus hand-written corner sequences for vpu_ctrl.
module tb_vpu_ctrl;

    localparam int unsigned NL = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned RW = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cfg_start;
    logic                 cfg_abort;
    logic [2:0]           cfg_mode;
    logic [RW-1:0]        cfg_rows;
    logic                 bias_wr_en;
    logic [1:0]           bias_wr_lane;
    logic signed [DW-1:0] bias_wr_data;
    logic                 sys_valid_in [NL];
    logic [2:0]           vpu_mode;
    logic signed [DW-1:0] vpu_bias_data_out [NL];
    logic                 busy;
    logic                 done;
    logic                 err;

    always #5 clk = ~clk;

    vpu_ctrl #(
        .VPU_WIDTH     (NL),
        .DATA_WIDTH_IN (DW),
        .ROW_W         (RW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .cfg_start         (cfg_start),
        .cfg_abort         (cfg_abort),
        .cfg_mode          (cfg_mode),
        .cfg_rows          (cfg_rows),
        .bias_wr_en        (bias_wr_en),
        .bias_wr_lane      (bias_wr_lane),
        .bias_wr_data      (bias_wr_data),
        .sys_valid_in      (sys_valid_in),
        .vpu_mode          (vpu_mode),
        .vpu_bias_data_out (vpu_bias_data_out),
        .busy              (busy),
        .done              (done),
        .err               (err)
    );

    typedef struct {
        logic          rst;
        logic          start;
        logic          abort;
        logic [2:0]    mode;
        logic [RW-1:0] rows;
        logic          bwe;
        logic [1:0]    blane;
        logic [DW-1:0] bdata;
        logic [3:0]    valid;
        logic [2:0]    e_mode;
        logic          e_busy;
        logic          e_done;
        logic          e_err;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(input logic r, input logic s, input logic a,
                                input logic [2:0] m, input logic [RW-1:0] rows,
                                input logic bwe, input logic [1:0] bl, input logic [DW-1:0] bd,
                                input logic [3:0] v, input logic [2:0] em,
                                input logic eb, input logic ed, input logic ee);
        vec_t x;
        x.rst = r; x.start = s; x.abort = a; x.mode = m; x.rows = rows;
        x.bwe = bwe; x.blane = bl; x.bdata = bd; x.valid = v;
        x.e_mode = em; x.e_busy = eb; x.e_done = ed; x.e_err = ee;
        return x;
    endfunction

    // Shorthands: quiet cycle, valids only, start (with optional abort), bias write, reset.
    function automatic vec_t quiet(input logic [2:0] em, input logic eb, input logic ed, input logic ee);
        return mk(0, 0, 0, 3'd0, 16'd0, 0, 2'd0, 32'd0, 4'b0000, em, eb, ed, ee);
    endfunction
    function automatic vec_t vld(input logic [3:0] v, input logic [2:0] em, input logic eb,
                                 input logic ed, input logic ee);
        return mk(0, 0, 0, 3'd0, 16'd0, 0, 2'd0, 32'd0, v, em, eb, ed, ee);
    endfunction
    function automatic vec_t strt(input logic [2:0] m, input logic [RW-1:0] rows, input logic a,
                                  input logic [2:0] em, input logic eb, input logic ed, input logic ee);
        return mk(0, 1, a, m, rows, 0, 2'd0, 32'd0, 4'b0000, em, eb, ed, ee);
    endfunction
    function automatic vec_t bw(input logic [1:0] l, input logic [DW-1:0] d, input logic [2:0] em,
                                input logic eb, input logic ed, input logic ee);
        return mk(0, 0, 0, 3'd0, 16'd0, 1, l, d, 4'b0000, em, eb, ed, ee);
    endfunction
    function automatic vec_t rstv();
        return mk(1, 0, 0, 3'd0, 16'd0, 0, 2'd0, 32'd0, 4'b0000, 3'd0, 0, 0, 0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then compare the outputs just after the edge.
    task automatic apply(input vec_t v, input string tag);
        rst          = v.rst;
        cfg_start    = v.start;
        cfg_abort    = v.abort;
        cfg_mode     = v.mode;
        cfg_rows     = v.rows;
        bias_wr_en   = v.bwe;
        bias_wr_lane = v.blane;
        bias_wr_data = v.bdata;
        for (int i = 0; i < NL; i++) sys_valid_in[i] = v.valid[i];
        @(posedge clk);
        #1;
        chk({tag, ".mode"}, 32'(vpu_mode), 32'(v.e_mode));
        chk({tag, ".busy"}, 32'(busy), 32'(v.e_busy));
        chk({tag, ".done"}, 32'(done), 32'(v.e_done));
        chk({tag, ".err"},  32'(err),  32'(v.e_err));
    endtask

    task automatic chk_bias(input string tag, input logic [DW-1:0] b0, input logic [DW-1:0] b1,
                            input logic [DW-1:0] b2, input logic [DW-1:0] b3);
        chk({tag, ".bias0"}, vpu_bias_data_out[0], b0);
        chk({tag, ".bias1"}, vpu_bias_data_out[1], b1);
        chk({tag, ".bias2"}, vpu_bias_data_out[2], b2);
        chk({tag, ".bias3"}, vpu_bias_data_out[3], b3);
    endtask

    initial begin
        rst = 1'b1; cfg_start = 1'b0; cfg_abort = 1'b0; cfg_mode = 3'd0; cfg_rows = '0;
        bias_wr_en = 1'b0; bias_wr_lane = 2'd0; bias_wr_data = '0;
        for (int i = 0; i < NL; i++) sys_valid_in[i] = 1'b0;

        // Reset, bias load, rows=1 tile
        vecs.push_back(rstv());
        vecs.push_back(bw(2'd0, 32'd5, 3'd0, 0, 0, 0));
        vecs.push_back(bw(2'd1, 32'd6, 3'd0, 0, 0, 0));
        vecs.push_back(bw(2'd2, 32'd7, 3'd0, 0, 0, 0));
        vecs.push_back(bw(2'd3, 32'd8, 3'd0, 0, 0, 0));
        vecs.push_back(strt(3'd1, 16'd1, 0, 3'd1, 1, 0, 0));
        vecs.push_back(vld(4'b1111, 3'd1, 1, 0, 0));
        vecs.push_back(quiet(3'd1, 0, 1, 0));
        vecs.push_back(quiet(3'd1, 0, 0, 0));
        // rows=0 tile: done the next cycle, never busy
        vecs.push_back(strt(3'd2, 16'd0, 0, 3'd2, 0, 1, 0));
        vecs.push_back(quiet(3'd2, 0, 0, 0));
        // Skewed lanes, rows=3
        vecs.push_back(strt(3'd3, 16'd3, 0, 3'd3, 1, 0, 0));
        vecs.push_back(vld(4'b0001, 3'd3, 1, 0, 0));
        vecs.push_back(vld(4'b0011, 3'd3, 1, 0, 0));
        vecs.push_back(vld(4'b0111, 3'd3, 1, 0, 0));
        vecs.push_back(vld(4'b1110, 3'd3, 1, 0, 0));
        vecs.push_back(vld(4'b1100, 3'd3, 1, 0, 0));
        vecs.push_back(vld(4'b1000, 3'd3, 1, 0, 0));
        vecs.push_back(quiet(3'd3, 0, 1, 0));
        vecs.push_back(quiet(3'd3, 0, 0, 0));
        // Abort mid-RUN, then start+abort together (start wins), counters restarted
        vecs.push_back(strt(3'd4, 16'd2, 0, 3'd4, 1, 0, 0));
        vecs.push_back(vld(4'b1111, 3'd4, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 3'd0, 16'd0, 0, 2'd0, 32'd0, 4'b0000, 3'd4, 0, 0, 0));
        vecs.push_back(quiet(3'd4, 0, 0, 0));
        vecs.push_back(strt(3'd5, 16'd1, 1, 3'd5, 1, 0, 0));
        vecs.push_back(quiet(3'd5, 1, 0, 0));
        vecs.push_back(quiet(3'd5, 1, 0, 0));
        vecs.push_back(vld(4'b1111, 3'd5, 1, 0, 0));
        vecs.push_back(quiet(3'd5, 0, 1, 0));
        vecs.push_back(quiet(3'd5, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("v%0d", i));
            if (i == 0) chk_bias("rst0", 32'd0, 32'd0, 32'd0, 32'd0);
        end
        chk_bias("loaded", 32'd5, 32'd6, 32'd7, 32'd8);

        // Excess valid on lane 1: err sticks, tile still completes
        apply(strt(3'd1, 16'd2, 0, 3'd1, 1, 0, 0), "exc.start");
        apply(vld(4'b1111, 3'd1, 1, 0, 0), "exc.v1");
        apply(vld(4'b0010, 3'd1, 1, 0, 0), "exc.v2");
        apply(vld(4'b0010, 3'd1, 1, 0, 1), "exc.v3");
        apply(vld(4'b1101, 3'd1, 1, 0, 1), "exc.v4");
        apply(quiet(3'd1, 0, 1, 1), "exc.done");
        apply(quiet(3'd1, 0, 0, 1), "exc.idle");

        // Reset clears err, mode and bias
        apply(rstv(), "rst1");
        chk_bias("rst1", 32'd0, 32'd0, 32'd0, 32'd0);

        // Bias write during RUN is dropped; reset mid-tile gives no done
        apply(strt(3'd6, 16'd1, 0, 3'd6, 1, 0, 0), "bwr.start");
        apply(bw(2'd2, 32'hFFFF_FFFD, 3'd6, 1, 0, 1), "bwr.write");
        chk_bias("bwr", 32'd0, 32'd0, 32'd0, 32'd0);
        apply(rstv(), "bwr.rst");
        apply(quiet(3'd0, 0, 0, 0), "bwr.q1");
        apply(quiet(3'd0, 0, 0, 0), "bwr.q2");

        // Start outside IDLE is ignored (mode kept) but flags err
        apply(strt(3'd6, 16'd1, 0, 3'd6, 1, 0, 0), "sti.start");
        apply(strt(3'd2, 16'd5, 0, 3'd6, 1, 0, 1), "sti.again");
        apply(vld(4'b1111, 3'd6, 1, 0, 1), "sti.v");
        apply(quiet(3'd6, 0, 1, 1), "sti.done");
        apply(quiet(3'd6, 0, 0, 1), "sti.idle");

        // Valid while idle flags err; signed bias write in IDLE lands
        apply(rstv(), "rst2");
        apply(bw(2'd3, 32'hFFFF_FFFD, 3'd0, 0, 0, 0), "neg.write");
        chk_bias("neg", 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFD);
        apply(vld(4'b0100, 3'd0, 0, 0, 1), "ivl.v");
        apply(quiet(3'd0, 0, 0, 1), "ivl.hold");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
